// File: rtl/status_register.sv
// Producer of the {N,Z,C,V} status word: flags are computed from the execute-stage op,
// captured, then committed. Define STATUS_BYPASS_EN to expose captured flags combinationally.
module status_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] result,
    input  logic             freeze,
    input  logic             flush,
    output logic [3:0]       status,
    output logic             status_pending
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic       vld_p1;
    logic [3:0] flags_p1;
    logic [3:0] status_reg;
    logic [3:0] flags_p0;
    logic       listed_p0;
    logic       cin_fwd;
    logic       vin_fwd;

    function automatic logic cmd_listed(input logic [3:0] cmd);
        case (cmd)
            CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
            CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: cmd_listed = 1'b1;
            default:                            cmd_listed = 1'b0;
        endcase
    endfunction

    // Carry/borrow are evaluated one bit wider than the operands; bit WIDTH is the carry out.
    function automatic logic [3:0] calc_flags(
        input logic [3:0]       cmd,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] r,
        input logic             cin,
        input logic             vin
    );
        logic [WIDTH:0] ext;
        logic           n;
        logic           z;
        logic           c;
        logic           v;
        ext = '0;
        n   = r[WIDTH-1];
        z   = (r == '0);
        c   = cin;
        v   = vin;
        case (cmd)
            CMD_ADD, CMD_ADC: begin
                ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (cmd == CMD_ADC) & cin};
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (cmd == CMD_SBC) & ~cin};
                c   = ~ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            default: ;
        endcase
        calc_flags = {n, z, c, v};
    endfunction

    // Stage p0: flag computation, forwarding C/V from an uncommitted capture
    always_comb begin
        cin_fwd   = vld_p1 ? flags_p1[1] : status_reg[1];
        vin_fwd   = vld_p1 ? flags_p1[0] : status_reg[0];
        listed_p0 = cmd_listed(exe_cmd);
        flags_p0  = calc_flags(exe_cmd, op_a, op_b, result, cin_fwd, vin_fwd);
    end

    // Stage p1: capture; commit into the architectural register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            status_reg <= 4'b0000;
        end else if (!freeze) begin
            vld_p1 <= upd_valid & ~flush & listed_p0;
            if (vld_p1) begin
                status_reg <= flags_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!freeze) begin
            flags_p1 <= flags_p0;
        end
    end

`ifdef STATUS_BYPASS_EN
    assign status         = vld_p1 ? flags_p1 : status_reg;
    assign status_pending = 1'b0;
`else
    assign status         = status_reg;
    assign status_pending = vld_p1;
`endif

endmodule
